// File: rtl/mesa_ro_pkg.sv
// Shared types and constants for the Mesa Bus readout frame buffer.
package mesa_ro_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_READY = 2'd2,
        ST_DUMP  = 2'd3
    } fb_state_t;

    // Longest supported push_done delay line.
    localparam int DONE_DLY_MAX = 8;

endpackage

// File: rtl/mesa_sdp_ram.sv
// Simple dual-port inferred RAM with a write port and a clock-enabled registered read port.
module mesa_sdp_ram #(
    parameter int data_bits  = 8,
    parameter int depth_bits = 9
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [depth_bits-1:0] wr_addr,
    input  logic [data_bits-1:0]  wr_data,
    input  logic                  rd_ce,
    input  logic                  rd_en,
    input  logic [depth_bits-1:0] rd_addr,
    output logic [data_bits-1:0]  rd_data
);

    logic [data_bits-1:0] mem [0:(1 << depth_bits) - 1];

    // NOTE: no reset on the array or the read register, so the tools can map this onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_ce && rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/mesa_ro_frame_buffer.sv
// Store-then-dump frame buffer: collects readback words until the frame closes,
// then replays the frame as one contiguous burst paced by pop_ck_en.
module mesa_ro_frame_buffer
    import mesa_ro_pkg::*;
#(
    parameter int data_bits  = 8,
    parameter int depth_len  = 512,
    parameter int depth_bits = 9,
    parameter int done_dly   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pop_ck_en,
    input  logic                  flush,
    input  logic                  din_en,
    input  logic [data_bits-1:0]  din_d,
    input  logic                  push_done,
    input  logic                  pop_en,
    output logic                  pop_rdy,
    output logic                  dout_rdy,
    output logic [data_bits-1:0]  dout_d,
    output logic [depth_bits:0]   frame_len,
    output logic                  overflow,
    output logic                  dump_done,
    output logic                  busy
);

    // Delay length clamped into the supported 1..DONE_DLY_MAX range.
    localparam int DLY = (done_dly < 1) ? 1 :
                         (done_dly > DONE_DLY_MAX) ? DONE_DLY_MAX : done_dly;
    localparam logic [depth_bits:0] FULL = (depth_bits + 1)'(depth_len);

    fb_state_t              state;
    logic [depth_bits:0]    wr_cnt;
    logic [depth_bits:0]    rd_ptr;
    logic [DLY-1:0]         done_line;
    logic                   close_pend;
    logic                   wr_en_q;
    logic [depth_bits-1:0]  wr_addr_q;
    logic [data_bits-1:0]   wr_data_q;
    logic                   pop_en_q;
    logic                   rd_vld_q;
    logic [data_bits-1:0]   ram_q;

    logic fill_open;
    logic accept;
    logic pop_start;
    logic rd_issue;

    // Writes are taken in IDLE (first word of a frame) and in FILL until the close edge.
    assign fill_open = (state == ST_IDLE) || ((state == ST_FILL) && !close_pend);
    assign accept    = din_en && fill_open && (wr_cnt != FULL);
    assign pop_start = (state == ST_READY) && pop_ck_en && pop_en && !pop_en_q;
    assign rd_issue  = (state == ST_DUMP) && pop_ck_en && (rd_ptr < frame_len);
    assign busy      = (state != ST_IDLE);

    mesa_sdp_ram #(
        .data_bits  (data_bits),
        .depth_bits (depth_bits)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en_q),
        .wr_addr (wr_addr_q),
        .wr_data (wr_data_q),
        .rd_ce   (pop_ck_en),
        .rd_en   (rd_issue),
        .rd_addr (rd_ptr[depth_bits-1:0]),
        .rd_data (ram_q)
    );

    // NOTE: every register here is state, so only non-blocking assignments; later ones in the block win.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            wr_cnt     <= '0;
            rd_ptr     <= '0;
            done_line  <= '0;
            close_pend <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            pop_en_q   <= 1'b0;
            rd_vld_q   <= 1'b0;
            pop_rdy    <= 1'b0;
            dout_rdy   <= 1'b0;
            dout_d     <= '0;
            frame_len  <= '0;
            overflow   <= 1'b0;
            dump_done  <= 1'b0;
        end else begin
            dump_done <= 1'b0;
            wr_en_q   <= 1'b0;
            if (pop_ck_en) begin
                pop_en_q <= pop_en;
            end

            if (flush) begin
                state      <= ST_IDLE;
                pop_rdy    <= 1'b0;
                dout_rdy   <= 1'b0;
                done_line  <= '0;
                close_pend <= 1'b0;
                wr_cnt     <= '0;
                rd_vld_q   <= 1'b0;
            end else begin
                done_line[0] <= push_done && fill_open;
                for (int i = DLY - 1; i > 0; i--) begin
                    done_line[i] <= done_line[i-1];
                end
                // One extra cycle after the pulse exits lets the staged write land first.
                close_pend <= (state == ST_FILL) && done_line[DLY-1] && !close_pend;

                if (accept) begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= wr_cnt[depth_bits-1:0];
                    wr_data_q <= din_d;
                    wr_cnt    <= wr_cnt + 1'b1;
                end else if (din_en && fill_open) begin
                    overflow <= 1'b1;
                end

                case (state)
                    ST_IDLE: begin
                        if (din_en || push_done) begin
                            state    <= ST_FILL;
                            overflow <= 1'b0;
                        end
                    end
                    ST_FILL: begin
                        if (close_pend) begin
                            frame_len <= wr_cnt;
                            pop_rdy   <= 1'b1;
                            state     <= ST_READY;
                        end
                    end
                    ST_READY: begin
                        if (pop_start) begin
                            pop_rdy <= 1'b0;
                            rd_ptr  <= '0;
                            state   <= ST_DUMP;
                        end
                    end
                    ST_DUMP: begin
                        // RAM read, then output register: word k appears two enabled cycles after its read slot opens.
                        if (pop_ck_en) begin
                            if (rd_issue) begin
                                rd_ptr <= rd_ptr + 1'b1;
                            end
                            rd_vld_q <= rd_issue;
                            dout_rdy <= rd_vld_q;
                            if (rd_vld_q) begin
                                dout_d <= ram_q;
                            end
                            if (!rd_issue && !rd_vld_q) begin
                                dump_done <= 1'b1;
                                wr_cnt    <= '0;
                                state     <= ST_IDLE;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mesa_ro_frame_buffer.sv
// Randomised self-checking bench for mesa_ro_frame_buffer against a queue-based frame model.
module tb_mesa_ro_frame_buffer;

    localparam int DW    = 8;
    localparam int DEPTH = 512;
    localparam int AW    = 9;
    localparam int DLY   = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          pop_ck_en = 1'b1;
    logic          flush = 1'b0;
    logic          din_en = 1'b0;
    logic [DW-1:0] din_d = '0;
    logic          push_done = 1'b0;
    logic          pop_en = 1'b0;
    logic          pop_rdy;
    logic          dout_rdy;
    logic [DW-1:0] dout_d;
    logic [AW:0]   frame_len;
    logic          overflow;
    logic          dump_done;
    logic          busy;

    int total = 0;
    int bad   = 0;

    // Model: the words the frame should hold and whether any write was dropped.
    logic [DW-1:0] model_q[$];
    bit            model_ovf;

    mesa_ro_frame_buffer #(
        .data_bits  (DW),
        .depth_len  (DEPTH),
        .depth_bits (AW),
        .done_dly   (DLY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pop_ck_en (pop_ck_en),
        .flush     (flush),
        .din_en    (din_en),
        .din_d     (din_d),
        .push_done (push_done),
        .pop_en    (pop_en),
        .pop_rdy   (pop_rdy),
        .dout_rdy  (dout_rdy),
        .dout_d    (dout_d),
        .frame_len (frame_len),
        .overflow  (overflow),
        .dump_done (dump_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pop_rdy"}, pop_rdy, 0);
        check({tag, "_dout_rdy"}, dout_rdy, 0);
        check({tag, "_dout_d"}, dout_d, 0);
        check({tag, "_frame_len"}, frame_len, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_dump_done"}, dump_done, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic new_frame();
        model_q.delete();
        model_ovf = 1'b0;
    endtask

    function automatic void model_push(input logic [DW-1:0] d);
        if (model_q.size() < DEPTH) model_q.push_back(d);
        else model_ovf = 1'b1;
    endfunction

    task automatic push_word(input logic [DW-1:0] d, input int gap);
        din_en = 1'b1;
        din_d  = d;
        model_push(d);
        tick();
        din_en = 1'b0;
        repeat (gap) tick();
    endtask

    // Pulse push_done, optionally push words in the closing window, and time pop_rdy.
    task automatic close_frame(input int nwin);
        int n;
        push_done = 1'b1;
        tick();
        push_done = 1'b0;
        n = 0;
        for (int i = 0; i < nwin; i++) begin
            din_en = 1'b1;
            din_d  = DW'($urandom);
            model_push(din_d);
            tick();
            n++;
        end
        din_en = 1'b0;
        while (pop_rdy !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("close_latency", n, DLY + 1);
        check("close_frame_len", frame_len, model_q.size());
        check("close_overflow", overflow, model_ovf);
        check("close_busy", busy, 1);
    endtask

    // mode 0: pop_ck_en always high, 1: toggling, 2: random.
    task automatic dump(input int mode, input bit hold_pop);
        int n, e, clks;
        bit done_seen, ck, exp_rdy, exp_done, cur_rdy;
        logic [DW-1:0] cur_d;
        n = model_q.size();
        e = 0;
        clks = 0;
        done_seen = 1'b0;
        cur_rdy = 1'b0;
        cur_d = '0;
        pop_ck_en = 1'b1;
        pop_en = 1'b1;
        tick();
        if (!hold_pop) pop_en = 1'b0;
        check("start_pop_rdy", pop_rdy, 0);
        check("start_busy", busy, 1);
        check("start_dout_rdy", dout_rdy, 0);
        while (!done_seen && clks < 8 * n + 64) begin
            case (mode)
                0:       ck = 1'b1;
                1:       ck = ((clks % 2) == 1);
                default: ck = 1'($urandom_range(0, 1));
            endcase
            pop_ck_en = ck;
            tick();
            clks++;
            if (ck) begin
                e++;
                exp_rdy  = (e >= 2) && (e <= n + 1);
                exp_done = (n == 0) ? (e == 1) : (e == n + 2);
                check("dout_rdy", dout_rdy, exp_rdy);
                if (exp_rdy) begin
                    check("dout_d", dout_d, model_q[e-2]);
                    cur_d = model_q[e-2];
                end
                cur_rdy = exp_rdy;
                check("dump_done", dump_done, exp_done);
                if (exp_done) begin
                    check("end_busy", busy, 0);
                    done_seen = 1'b1;
                end
            end else begin
                check("hold_rdy", dout_rdy, cur_rdy);
                if (cur_rdy) check("hold_d", dout_d, cur_d);
                check("disabled_done", dump_done, 0);
            end
        end
        check("dump_finished", done_seen, 1);
        pop_ck_en = 1'b1;
        tick();
        check("done_one_clk", dump_done, 0);
        check("post_dout_rdy", dout_rdy, 0);
        check("post_frame_len", frame_len, n);
        check("post_overflow", overflow, model_ovf);
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Basic frame 0x11..0x15 with gaps, full-rate dump
        new_frame();
        for (int i = 0; i < 5; i++) push_word(DW'(8'h11 + i), $urandom_range(1, 3));
        check("fill_busy", busy, 1);
        close_frame(0);
        dump(0, 1'b0);

        // Same frame, pop_ck_en toggling
        new_frame();
        for (int i = 0; i < 5; i++) push_word(DW'(8'h11 + i), $urandom_range(0, 2));
        close_frame(0);
        dump(1, 1'b0);

        // Random frames with random pacing and trailing window writes
        for (int f = 0; f < 3; f++) begin
            new_frame();
            for (int i = 0; i < int'($urandom_range(1, 20)); i++)
                push_word(DW'($urandom), $urandom_range(0, 2));
            close_frame($urandom_range(0, 2));
            dump(2, 1'b0);
        end

        // Overflow: 514 words into a 512-deep buffer
        new_frame();
        for (int i = 0; i < DEPTH + 2; i++) push_word(DW'(i), 0);
        close_frame(0);
        check("ovf_flag", overflow, 1);
        check("ovf_len", frame_len, DEPTH);
        dump(0, 1'b0);

        // Zero-length frame
        new_frame();
        close_frame(0);
        dump(0, 1'b0);

        // Two words written inside the closing window
        new_frame();
        for (int i = 0; i < 3; i++) push_word(DW'($urandom), 0);
        close_frame(2);
        check("window_len", frame_len, 5);
        dump(0, 1'b0);

        // Flush after word 2 of an 8-word dump
        new_frame();
        for (int i = 0; i < 8; i++) push_word(DW'($urandom), 0);
        close_frame(0);
        pop_en = 1'b1;
        tick();
        pop_en = 1'b0;
        tick();
        tick();
        check("flush_w0_rdy", dout_rdy, 1);
        check("flush_w0", dout_d, model_q[0]);
        tick();
        check("flush_w1", dout_d, model_q[1]);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_dout_rdy", dout_rdy, 0);
        check("flush_pop_rdy", pop_rdy, 0);
        check("flush_busy", busy, 0);
        check("flush_dump_done", dump_done, 0);
        check("flush_frame_len", frame_len, 8);
        tick();
        new_frame();
        for (int i = 0; i < 3; i++) push_word(DW'($urandom), $urandom_range(0, 1));
        close_frame(0);
        dump(0, 1'b0);

        // Reset in the middle of a dump
        new_frame();
        for (int i = 0; i < 6; i++) push_word(DW'($urandom | 1), 0);
        close_frame(0);
        pop_en = 1'b1;
        tick();
        pop_en = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check_all_zero("mid_reset");
        reset = 1'b0;
        tick();

        // pop_en held high across two frames
        new_frame();
        for (int i = 0; i < 2; i++) push_word(DW'($urandom), 0);
        close_frame(0);
        dump(0, 1'b1);
        new_frame();
        for (int i = 0; i < 2; i++) push_word(DW'($urandom), 0);
        close_frame(0);
        repeat (4) begin
            tick();
            check("held_pop_rdy", pop_rdy, 1);
            check("held_busy", busy, 1);
            check("held_dout_rdy", dout_rdy, 0);
        end
        pop_en = 1'b0;
        tick();
        check("fall_pop_rdy", pop_rdy, 1);
        dump(0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mesa_ro_frame_buffer.md
Name: mesa_ro_frame_buffer

Overview:
Parametrised store-then-dump frame buffer for the Mesa Bus readout path. It collects an intermittent stream of readback words until the frame is closed, then emits the frame as one gap-free burst paced by a pop clock enable. Width and depth are generic. Over the previous byte buffer it adds overflow detection, a frame-length output, a flush, zero-length frame handling and a dump-complete pulse.

Parameters:
data_bits, 8, width of din_d/dout_d
depth_len, 512, RAM depth in words
depth_bits, 9, log2(depth_len)
done_dly, 4, cycles push_done is delayed before the frame closes (1..8); covers writes that trail push_done

Ports:
clk  in  1  sole clock
reset  in  1  synchronous, active-high; all state cleared on the clk edge where it is high
pop_ck_en  in  1  pop-side clock enable; all pop-side logic advances only when high
flush  in  1  synchronous abort; discards the frame, returns to IDLE
din_en  in  1  write strobe for din_d
din_d  in  data_bits  write data
push_done  in  1  pulse: the current frame is complete
pop_en  in  1  rising edge (sampled on pop_ck_en cycles) starts the dump
pop_rdy  out  1  frame closed and waiting for pop_en
dout_rdy  out  1  dout_d valid on this pop_ck_en cycle
dout_d  out  data_bits  dump data
frame_len  out  depth_bits+1  words stored in the closed frame (0..depth_len)
overflow  out  1  sticky: a write was dropped in the current frame
dump_done  out  1  one-clk pulse after the last word is emitted
busy  out  1  state is not IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; wr_cnt, rd_ptr, frame_len 0; done delay line cleared.
- States: IDLE, FILL, READY, DUMP.
- IDLE -> FILL on din_en: overflow cleared, word 0 written.
- IDLE -> FILL on push_done: a zero-length frame.
- FILL writes:
  - Input is registered one cycle before the RAM write.
  - wr_cnt increments per accepted word.
  - If din_en arrives with wr_cnt == depth_len, the word is dropped and overflow <= 1.
- Frame close: push_done enters a done_dly-stage shift register.
  - din_en continues to be accepted while the pulse is in flight.
  - When it exits: frame_len <= wr_cnt, pop_rdy <= 1, state READY.
  - wr_cnt is reset on entry to IDLE.
- READY and DUMP: din_en is ignored (no write, no overflow). push_done is ignored.
- READY -> DUMP on a pop_ck_en cycle with pop_en == 1 and previous sampled pop_en == 0:
  - pop_rdy <= 0, rd_ptr <= 0.
  - pop_en held high does not retrigger.
- DUMP pipeline, counted in pop_ck_en cycles only; E0 is the start edge:
  - RAM reads rd_ptr at E1..E(frame_len).
  - dout_rdy = 1 with word k at E(k+2).
  - The burst is contiguous: exactly frame_len cycles with dout_rdy high.
- While pop_ck_en is low, dout_rdy and dout_d hold. Consumers qualify with dout_rdy & pop_ck_en.
- After the last word: dout_rdy <= 0 on the next enabled cycle, dump_done pulses for one clk, state IDLE.
- Zero-length frame: on the start edge, no dout_rdy. dump_done pulses on E1, then IDLE.
- frame_len and overflow hold through DUMP and IDLE until the next frame starts.
- flush (any state): state IDLE, pop_rdy, dout_rdy and dump_done 0, done line cleared, wr_cnt 0. frame_len and overflow are retained. The RAM contents are not cleared.
- reset outranks flush. flush outranks din_en, push_done and pop_en in the same cycle.
- Read-during-write cannot occur: the two sides are separated by state.

Decomposition:
- Package mesa_ro_pkg: state encoding (2-bit enum IDLE/FILL/READY/DUMP) and the done_dly maximum constant.
- One sub-module, mesa_sdp_ram: simple dual-port inferred RAM, write port plus read port with read enable and clock enable, parametrised on data_bits/depth_bits.

Test Plan:
- Push 5 words 0x11..0x15 with gaps, push_done, pop_en rise with pop_ck_en=1:
  - pop_rdy high done_dly+1 clks after push_done.
  - frame_len=5.
  - dout_rdy for 5 consecutive clks starting 2 clks after the edge, data 0x11..0x15.
  - dump_done pulse, then busy=0.
- Same frame with pop_ck_en toggling 1/0 every clk: 5 enabled cycles carry dout_rdy, order intact, dout_d held on disabled clks.
- Push 514 words with depth_len=512: overflow=1, frame_len=512, dump returns words 0..511 only.
- push_done with no data, then pop_en: frame_len=0, no dout_rdy, one dump_done pulse, state IDLE.
- 2 words pushed in the done_dly window after push_done: both are included, frame_len counts them.
- Assert flush mid-dump after word 2 of 8: dout_rdy low next clk, pop_rdy=0, busy=0. A following 3-word frame dumps correctly.
- Assert reset mid-dump: every output 0 on the next clk.
- Hold pop_en high across two frames: the second dump occurs only after pop_en falls and rises again.
